// File: rtl/instruction_encoder.sv
// ----------------------------------------------------------------------------
// instruction_encoder
//
// Packs VR16 instruction fields into 16-bit instruction words using the bit
// layout the decoder expects. Accepted words are queued in a small FIFO and
// streamed out over a valid/ready interface. Field sets whose immediate does
// not fit the target encoding are consumed but dropped, and flagged on err.
// Encoding HALT stops intake until resume is pulsed.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready input handshake for one field set
//   in_opcode         VR16 opcode, lands in bits [15:12]
//   in_dest           destination register (R/I-type, DELETE)
//   in_src1, in_src2  source registers (R-type)
//   in_reg            register operand (STOREI)
//   in_imm            immediate value or jump address
//   resume            leave the halted state
//   out_valid/out_ready, out_instruction  FIFO head stream
//   halted            intake stopped after a HALT
//   err               one-cycle pulse after a rejected set was consumed
//   err_count         saturating count of rejected sets
//   issued_count      count of output handshakes, wraps at 16 bits
// ----------------------------------------------------------------------------
module instruction_encoder #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [1:0]  in_dest,
  input  logic [1:0]  in_src1,
  input  logic [1:0]  in_src2,
  input  logic [1:0]  in_reg,
  input  logic [15:0] in_imm,
  input  logic        resume,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instruction,
  output logic        halted,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] issued_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_ADDI   = 4'h1,
    OP_SUB    = 4'h2,
    OP_SUBI   = 4'h3,
    OP_MUL    = 4'h4,
    OP_MULI   = 4'h5,
    OP_DIV    = 4'h6,
    OP_DIVI   = 4'h7,
    OP_STOREI = 4'h8,
    OP_JUMP   = 4'h9,
    OP_DELETE = 4'hA,
    OP_AND    = 4'hB,
    OP_OR     = 4'hC,
    OP_NOT    = 4'hD,
    OP_XOR    = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e              state_q;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]         mem_q [DEPTH];
  logic                err_q, err_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [15:0]         issued_q, issued_d;

  opcode_e     op;
  logic [15:0] word;
  logic        reject;
  logic        fifo_empty, fifo_full;
  logic        accept, push, pop;

  // --------------------------------------------------------------------------
  // Field packing and range checks
  // --------------------------------------------------------------------------
  assign op = opcode_e'(in_opcode);

  always_comb begin
    word   = '0;
    reject = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_AND, OP_OR, OP_NOT, OP_XOR: begin
        word = {in_opcode, in_dest, in_src1, in_src2, 6'b0};
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_DIVI: begin
        word   = {in_opcode, in_dest, in_imm[9:0]};
        reject = |in_imm[15:10];
      end
      OP_STOREI: begin
        word   = {in_opcode, 2'b00, in_reg, in_imm[7:0]};
        reject = |in_imm[15:8];
      end
      OP_JUMP: begin
        word   = {in_opcode, in_imm[11:0]};
        reject = |in_imm[15:12];
      end
      OP_DELETE: begin
        word = {in_opcode, in_dest, 10'b0};
      end
      OP_HALT: begin
        word = {in_opcode, 12'b0};
      end
      default: begin
        word   = '0;
        reject = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO status: extra pointer MSB distinguishes full from empty
  // --------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                      (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  // Ready depends on registered state only, so a same-cycle pop never
  // opens a slot for a push.
  assign in_ready = (state_q == ST_RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !reject;
  assign pop      = !fifo_empty && out_ready;

  // --------------------------------------------------------------------------
  // Next-state for pointers and counters
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    err_d       = accept && reject;
    err_count_d = err_count_q;
    if (accept && reject && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
    issued_d = pop ? issued_q + 16'd1 : issued_q;
  end

  // --------------------------------------------------------------------------
  // State, storage and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      issued_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          // A rejected set never carries the HALT opcode, so accept is enough.
          if (accept && (op == OP_HALT)) begin
            state_q <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase

      if (push) begin
        mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= word;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      issued_q    <= issued_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid       = !fifo_empty;
  assign out_instruction = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign halted          = (state_q == ST_HALTED);
  assign err             = err_q;
  assign err_count       = err_count_q;
  assign issued_count    = issued_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// ----------------------------------------------------------------------------
// tb_instruction_encoder
//
// Directed bench for instruction_encoder (DEPTH_LOG2 = 2). Inputs are driven
// and outputs sampled 1 time unit after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [1:0]  in_dest = '0;
  logic [1:0]  in_src1 = '0;
  logic [1:0]  in_src2 = '0;
  logic [1:0]  in_reg = '0;
  logic [15:0] in_imm = '0;
  logic        resume = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instruction;
  logic        halted;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] issued_count;

  int checks = 0;
  int errors = 0;
  int exp_issued = 0;
  int exp_errs = 0;

  instruction_encoder #(.DEPTH_LOG2(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_opcode       (in_opcode),
    .in_dest         (in_dest),
    .in_src1         (in_src1),
    .in_src2         (in_src2),
    .in_reg          (in_reg),
    .in_imm          (in_imm),
    .resume          (resume),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .halted          (halted),
    .err             (err),
    .err_count       (err_count),
    .issued_count    (issued_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [1:0] rg, input logic [15:0] imm);
    in_opcode = op;
    in_dest   = d;
    in_src1   = s1;
    in_src2   = s2;
    in_reg    = rg;
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  // Push one set into an empty FIFO, check the word one cycle later, pop it.
  task automatic enc_ok(input string tag, input logic [3:0] op, input logic [1:0] d,
                        input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] rg,
                        input logic [15:0] imm, input logic [15:0] exp_word);
    out_ready = 1'b0;
    drive(op, d, s1, s2, rg, imm);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_nobypass"}, out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_word"}, out_instruction, exp_word);
    chk({tag, "_err"}, err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_issued++;
    chk({tag, "_popped"}, out_valid, 0);
    chk({tag, "_issued"}, issued_count, exp_issued);
  endtask

  task automatic enc_rej(input string tag, input logic [3:0] op, input logic [1:0] d,
                         input logic [15:0] imm);
    out_ready = 1'b0;
    drive(op, d, 2'd0, 2'd0, 2'd0, imm);
    tick();
    in_valid = 1'b0;
    exp_errs++;
    chk({tag, "_err"}, err, 1);
    chk({tag, "_noword"}, out_valid, 0);
    chk({tag, "_errcnt"}, err_count, exp_errs);
    tick();
    chk({tag, "_errpulse"}, err, 0);
  endtask

  function automatic logic [15:0] wordf(input int i);
    logic [15:0] imm;
    imm = 16'(i * 37);
    return {4'h1, 2'(i % 4), imm[9:0]};
  endfunction

  task automatic drive_w(input int i);
    drive(4'h1, 2'(i % 4), 2'd0, 2'd0, 2'd0, 16'(i * 37));
  endtask

  initial begin
    logic [15:0] q[$];
    int idx;
    int cyc;
    logic do_push, do_pop;

    // ---------------- reset ----------------
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_out_instr", out_instruction, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // ---------------- encodings ----------------
    enc_ok("add", 4'h0, 2'd1, 2'd2, 2'd3, 2'd0, 16'h0000, 16'h06C0);
    enc_ok("addi", 4'h1, 2'd2, 2'd0, 2'd0, 2'd0, 16'h03FF, 16'h1BFF);
    enc_rej("addi_rng", 4'h1, 2'd2, 16'h0400);
    enc_ok("storei", 4'h8, 2'd1, 2'd2, 2'd1, 2'd3, 16'h00A5, 16'h83A5);
    enc_rej("storei_rng", 4'h8, 2'd0, 16'h0100);
    enc_ok("jump", 4'h9, 2'd3, 2'd3, 2'd3, 2'd3, 16'h0123, 16'h9123);
    enc_rej("jump_rng", 4'h9, 2'd0, 16'h1000);
    enc_ok("delete", 4'hA, 2'd2, 2'd3, 2'd1, 2'd3, 16'hFFFF, 16'hA800);
    enc_ok("xor_dc", 4'hE, 2'd0, 2'd1, 2'd2, 2'd3, 16'hFFFF, 16'hE180);
    enc_ok("divi_max", 4'h7, 2'd3, 2'd0, 2'd0, 2'd0, 16'h03FF, 16'h7FFF);

    // ---------------- HALT / resume ----------------
    out_ready = 1'b0;
    drive(4'hF, 2'd3, 2'd3, 2'd3, 2'd3, 16'hFFFF);
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_in_ready", in_ready, 0);
    chk("halt_word", out_instruction, 16'hF000);
    chk("halt_valid", out_valid, 1);
    drive(4'h0, 2'd1, 2'd2, 2'd3, 2'd0, 16'h0000);
    out_ready = 1'b1;
    tick();
    exp_issued++;
    out_ready = 1'b0;
    chk("halt_drained", out_valid, 0);
    chk("halt_issued", issued_count, exp_issued);
    tick();
    tick();
    chk("halt_no_intake", out_valid, 0);
    chk("halt_still", halted, 1);
    chk("halt_ready_low", in_ready, 0);
    in_valid = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_in_ready", in_ready, 1);
    chk("resume_no_word", out_valid, 0);

    // ---------------- full FIFO ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_w(i);
      tick();
    end
    drive_w(4);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_instruction, wordf(0));
    tick();
    chk("full_hold_ready", in_ready, 0);
    chk("full_head_stable", out_instruction, wordf(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_issued++;
    chk("full_after_pop_ready", in_ready, 1);
    chk("full_after_pop_head", out_instruction, wordf(1));
    tick();
    chk("full_refilled", in_ready, 0);

    // ---------------- random drain scoreboard ----------------
    q = {wordf(1), wordf(2), wordf(3), wordf(4)};
    idx = 5;
    cyc = 0;
    while ((idx < 20 || q.size() > 0) && cyc < 300) begin
      chk("sb_in_ready", in_ready, (q.size() < 4) ? 1 : 0);
      chk("sb_out_valid", out_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) chk("sb_word", out_instruction, q[0]);
      if (idx < 20) drive_w(idx);
      else in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      do_push = in_valid && (q.size() < 4);
      do_pop  = out_ready && (q.size() > 0);
      tick();
      if (do_pop) begin
        void'(q.pop_front());
        exp_issued++;
      end
      if (do_push) begin
        q.push_back(wordf(idx));
        idx++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("sb_complete", (idx == 20 && q.size() == 0) ? 1 : 0, 1);
    chk("sb_empty", out_valid, 0);
    chk("sb_issued", issued_count, exp_issued);

    // ---------------- reset mid-operation ----------------
    drive(4'h0, 2'd1, 2'd1, 2'd1, 2'd0, 16'h0000);
    tick();
    drive(4'h2, 2'd2, 2'd2, 2'd2, 2'd0, 16'h0000);
    tick();
    drive(4'hF, 2'd0, 2'd0, 2'd0, 2'd0, 16'h0000);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_halted", halted, 1);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_errcnt", err_count, exp_errs);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_errcnt", err_count, 0);
    chk("mid_rst_issued", issued_count, 0);
    tick();
    reset = 1'b0;
    exp_issued = 0;
    exp_errs = 0;
    #1;
    enc_ok("post_rst", 4'h0, 2'd3, 2'd0, 2'd1, 2'd0, 16'h0000, 16'h0C40);

    // ---------------- err_count saturation ----------------
    drive(4'h9, 2'd0, 2'd0, 2'd0, 2'd0, 16'hF000);
    for (int i = 0; i < 256; i++) tick();
    chk("sat_err_level", err, 1);
    in_valid = 1'b0;
    chk("sat_err_count", err_count, 8'hFF);
    chk("sat_no_word", out_valid, 0);
    tick();
    chk("sat_err_clear", err, 0);
    chk("sat_hold", err_count, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
